stream_vigenere_core: RTL and testbench
=======================================

// Module: stream_vigenere_core
// PURPOSE
//  Sequential, streaming successor to the combinational encrypt/decrypt pair.
//  Encrypts or decrypts one byte per cycle with a programmable Vigenere key of KEY_LEN bytes.
//  Uses valid/ready handshakes with sop/eop framing, so messages of any length need no array ports.
//  Sits between a byte source (UART/host FIFO) and a byte sink; mode is selectable per message.
// PARAMETERS
//  KEY_LEN  default 4   number of key bytes; key index wraps modulo KEY_LEN
//  LEN_W    default 16  width of message byte counter; count saturates at 2**LEN_W-1
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  key_we     in   1      key write strobe
//  key_addr   in   clog2(KEY_LEN)  key byte index to write
//  key_data   in   8      key byte, ASCII
//  mode       in   1      0=encrypt 1=decrypt; sampled on accepted sop byte
//  in_valid   in   1      input byte valid
//  in_ready   out  1      core can accept input byte
//  in_data    in   8      input byte, ASCII
//  in_sop     in   1      first byte of message
//  in_eop     in   1      last byte of message (may coincide with sop)
//  out_valid  out  1      output byte valid
//  out_ready  in   1      sink accepts output byte
//  out_data   out  8      processed byte
//  out_eop    out  1      marks last byte of message
//  busy       out  1      1 while FSM in RUN
//  msg_len    out  LEN_W  byte count of last completed message
//  drop_cnt   out  8      bytes dropped outside a frame; saturates at 255
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_eop=0, busy=0, msg_len=0, drop_cnt=0.
//  Reset also sets key bytes to 'A' (shift 0), key index to 0 and FSM to IDLE.
//  Reset mid-message discards the in-flight byte; no partial eop is emitted.
//  Accept: in_valid && in_ready. in_ready = !out_valid || out_ready; no combinational valid->ready path.
//  Latency: exactly 1 cycle, accepted byte -> registered out_data/out_valid.
//  out_data/out_eop remain stable while out_valid && !out_ready.
//  FSM IDLE:
//   - accepted byte with in_sop -> process it; latch mode; key index=0; count=1.
//   - that byte also eop -> stay IDLE, msg_len=1; else -> RUN.
//   - accepted byte without in_sop -> dropped; no output; drop_cnt++.
//  FSM RUN:
//   - each accepted byte is processed and count increments, saturating.
//   - in_eop -> msg_len<=count including this byte; go IDLE.
//   - in_sop in RUN restarts: key index=0, mode relatched, count=1; old msg_len kept.
//  Cipher:
//   - only 'A'..'Z' transformed. shift k = key[idx]-'A' if key byte is 'A'..'Z', else 0.
//   - encrypt: 'A'+((p-'A')+k) mod 26.
//   - decrypt: 'A'+((c-'A')+26-k) mod 26.
//   - arithmetic uses >=6-bit intermediates; a single conditional subtract of 26 is enough.
//   - key index advances (idx==KEY_LEN-1 -> 0) only on accepted letters.
//   - non-letters pass through unchanged and do not advance the index.
//  Key writes:
//   - accepted only when FSM is IDLE and no byte is accepted that cycle; ignored otherwise.
//   - key_addr>=KEY_LEN is ignored.
//   - a written byte takes effect from the next sop.
//  Simultaneous out_ready with new accept: output register reloads in the same cycle (full rate).
// TESTING
//  1 KEY_LEN=3, key "KEY", encrypt "HELLO" (sop on H, eop on O) -> "RIJVS", out_eop on S, msg_len=5.
//  2 Decrypt "RIJVS" with key "KEY" -> "HELLO"; the encrypt->decrypt loop reproduces a 23-byte test string exactly.
//  3 Encrypt "HI 5A", key "KEY" -> "RM 5Y": space and '5' unchanged, 'A' uses key 'Y'.
//  4 Wrap: encrypt 'Z' with key 'B' -> 'A'; decrypt 'A' with key 'B' -> 'Z'.
//  5 Backpressure: hold out_ready=0 for 5 cycles mid-message -> in_ready=0, out_data stable, no byte lost or duplicated.
//  6 Reset and framing:
//    - byte without sop in IDLE -> drop_cnt=1, no output.
//    - key write during RUN -> ignored.
//    - rst_n low mid-message -> all outputs 0, next sop message correct.

Source files
------------

// File: rtl/stream_vigenere_core.sv
// Streaming Vigenere encrypt/decrypt core: one byte per cycle, valid/ready in and out,
// sop/eop framing, programmable KEY_LEN-byte key, message length and drop statistics.
module stream_vigenere_core #(
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned LEN_W   = 16,
  localparam int unsigned KA_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_we,
  input  logic [KA_W-1:0]  key_addr,
  input  logic [7:0]       key_data,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_eop,
  output logic             busy,
  output logic [LEN_W-1:0] msg_len,
  output logic [7:0]       drop_cnt
);

  localparam logic [7:0]       CH_A     = 8'h41;
  localparam logic [7:0]       CH_Z     = 8'h5A;
  localparam logic [5:0]       ALPHA    = 6'd26;
  localparam logic [LEN_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       DROP_MAX = 8'hFF;
  localparam logic [KA_W-1:0]  IDX_LAST = KA_W'(KEY_LEN - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_key [KEY_LEN];
  logic [KA_W-1:0]  r_idx, w_idx_nxt;
  logic             r_mode, w_mode_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0] r_msg_len, w_msg_len_nxt;
  logic [7:0]       r_drop_cnt, w_drop_cnt_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [7:0]       r_out_data, w_out_data_nxt;
  logic             r_out_eop, w_out_eop_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_process;
  logic             w_drop;
  logic             w_key_wr;
  logic [KA_W-1:0]  w_cur_idx;
  logic [KA_W-1:0]  w_idx_adv;
  logic             w_cur_mode;
  logic [7:0]       w_key_byte;
  logic             w_key_is_letter;
  logic [5:0]       w_shift;
  logic             w_is_letter;
  logic [5:0]       w_p;
  logic [5:0]       w_sum;
  logic [5:0]       w_mod;
  logic [7:0]       w_cipher;
  logic [LEN_W-1:0] w_cnt_cur;

  // Handshake: ready depends only on the output register and the sink, never on in_valid.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_process  = w_accept && (in_sop || (r_state == S_RUN));
  assign w_drop     = w_accept && !in_sop && (r_state == S_IDLE);
  assign w_key_wr   = key_we && (r_state == S_IDLE) && !w_accept &&
                      (32'(key_addr) < KEY_LEN);

  // A sop byte starts from key index 0 with freshly sampled mode.
  assign w_cur_idx  = in_sop ? '0 : r_idx;
  assign w_cur_mode = in_sop ? mode : r_mode;
  assign w_idx_adv  = (w_cur_idx == IDX_LAST) ? '0 : w_cur_idx + KA_W'(1);

  assign w_key_byte      = r_key[w_cur_idx];
  assign w_key_is_letter = (w_key_byte >= CH_A) && (w_key_byte <= CH_Z);
  assign w_shift         = w_key_is_letter ? 6'(w_key_byte - CH_A) : 6'd0;

  assign w_is_letter = (in_data >= CH_A) && (in_data <= CH_Z);
  assign w_p         = 6'(in_data - CH_A);
  assign w_sum       = w_cur_mode ? (w_p + ALPHA - w_shift) : (w_p + w_shift);
  assign w_mod       = (w_sum >= ALPHA) ? (w_sum - ALPHA) : w_sum;
  assign w_cipher    = w_is_letter ? (CH_A + 8'(w_mod)) : in_data;

  assign w_cnt_cur = in_sop ? LEN_W'(1) :
                     ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + LEN_W'(1));

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_mode_nxt      = r_mode;
    w_cnt_nxt       = r_cnt;
    w_msg_len_nxt   = r_msg_len;
    w_drop_cnt_nxt  = r_drop_cnt;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_eop_nxt   = r_out_eop;

    if (w_drop && (r_drop_cnt != DROP_MAX)) begin
      w_drop_cnt_nxt = r_drop_cnt + 8'd1;
    end

    if (w_process) begin
      w_mode_nxt      = w_cur_mode;
      w_idx_nxt       = w_is_letter ? w_idx_adv : w_cur_idx;
      w_cnt_nxt       = w_cnt_cur;
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = w_cipher;
      w_out_eop_nxt   = in_eop;
      if (in_eop) begin
        w_msg_len_nxt = w_cnt_cur;
        w_state_nxt   = S_IDLE;
      end else begin
        w_state_nxt   = S_RUN;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_msg_len   <= '0;
      r_drop_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eop   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_mode      <= w_mode_nxt;
      r_cnt       <= w_cnt_nxt;
      r_msg_len   <= w_msg_len_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_eop   <= w_out_eop_nxt;
    end
  end

  // Key store; 'A' is a zero shift so the reset key is an identity cipher.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < KEY_LEN; i++) begin
        r_key[i] <= CH_A;
      end
    end else if (w_key_wr) begin
      r_key[key_addr] <= key_data;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_eop   = r_out_eop;
  assign busy      = (r_state == S_RUN);
  assign msg_len   = r_msg_len;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_vigenere_core.sv
// Directed self-checking bench for stream_vigenere_core (KEY_LEN=3).
module tb_stream_vigenere_core;

  localparam int unsigned KEY_LEN = 3;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned KA_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_we = 1'b0;
  logic [KA_W-1:0]  key_addr = '0;
  logic [7:0]       key_data = '0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_eop;
  logic             busy;
  logic [LEN_W-1:0] msg_len;
  logic [7:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] q[$];
  string ct;

  always #5 clk = ~clk;

  stream_vigenere_core #(.KEY_LEN(KEY_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eop(out_eop),
    .busy(busy), .msg_len(msg_len), .drop_cnt(drop_cnt)
  );

  // Output monitor: a transfer happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) q.push_back({out_eop, out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte b, input logic sop, input logic eop, input logic m);
    int n;
    in_valid = 1'b1; in_data = b; in_sop = sop; in_eop = eop; mode = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_str(input string s, input logic m);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], i == 0, i == s.len() - 1, m);
    end
  endtask

  task automatic write_key(input logic [KA_W-1:0] a, input byte d);
    key_we = 1'b1; key_addr = a; key_data = d;
    tick();
    key_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input string exp);
    logic [8:0] got;
    logic [7:0] e;
    repeat (2) tick();
    chk({tag, "_count"}, 32'(q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      if (q.size() > 0) begin
        got = q.pop_front();
        e = exp[i];
        chk($sformatf("%s_data%0d", tag, i), 32'(got[7:0]), 32'(e));
        chk($sformatf("%s_eop%0d", tag, i), 32'(got[8]), 32'(i == exp.len() - 1));
      end
    end
    q.delete();
  endtask

  task automatic collect(output string s);
    logic [8:0] got;
    repeat (2) tick();
    s = "";
    while (q.size() > 0) begin
      got = q.pop_front();
      s = $sformatf("%s%c", s, got[7:0]);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_eop",   32'(out_eop),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_msg_len",   32'(msg_len),   32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    write_key(2'd0, "K");
    write_key(2'd1, "E");
    write_key(2'd2, "Y");

    // Encrypt and decrypt HELLO
    send_str("HELLO", 1'b0);
    expect_out("enc_hello", "RIJVS");
    chk("enc_hello_len", 32'(msg_len), 32'd5);
    chk("enc_hello_busy", 32'(busy), 32'd0);
    send_str("RIJVS", 1'b1);
    expect_out("dec_hello", "HELLO");

    // 23-byte round trip
    send_str("ATTACK AT DAWN 0900 XYZ", 1'b0);
    collect(ct);
    chk("loop_ct_len", 32'(ct.len()), 32'd23);
    chk("loop_msg_len", 32'(msg_len), 32'd23);
    send_str(ct, 1'b1);
    expect_out("loop_pt", "ATTACK AT DAWN 0900 XYZ");

    // Non-letters pass through and do not advance the key
    send_str("HI 5A", 1'b0);
    expect_out("nonletter", "RM 5Y");
    chk("nonletter_len", 32'(msg_len), 32'd5);

    // Backpressure for 5 cycles mid-message
    fork
      send_str("HELLO", 1'b0);
      begin
        repeat (2) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
          chk($sformatf("bp_out_valid%0d", i), 32'(out_valid), 32'd1);
          chk($sformatf("bp_out_data%0d", i), 32'(out_data), 32'h49);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    expect_out("bp", "RIJVS");

    // Byte without sop in IDLE is dropped
    send_byte("Q", 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_no_output", 32'(q.size()), 32'd0);
    chk("drop_out_valid", 32'(out_valid), 32'd0);

    // Key write while RUN is ignored
    send_byte("A", 1'b1, 1'b0, 1'b0);
    chk("run_busy", 32'(busy), 32'd1);
    write_key(2'd0, "B");
    send_byte("A", 1'b0, 1'b1, 1'b0);
    expect_out("run_keywr_a", "KE");
    send_str("A", 1'b0);
    expect_out("run_keywr_b", "K");

    // Wrap-around with key 'B'
    write_key(2'd0, "B");
    send_str("Z", 1'b0);
    expect_out("wrap_enc", "A");
    chk("wrap_len", 32'(msg_len), 32'd1);
    send_str("A", 1'b1);
    expect_out("wrap_dec", "Z");

    // Reset mid-message
    send_byte("H", 1'b1, 1'b0, 1'b0);
    send_byte("E", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_out_eop",   32'(out_eop),   32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_msg_len",   32'(msg_len),   32'd0);
    chk("mid_rst_drop_cnt",  32'(drop_cnt),  32'd0);
    tick();
    rst_n = 1'b1;
    q.delete();
    tick();
    send_str("HI", 1'b0);
    expect_out("post_rst", "HI");
    chk("post_rst_len", 32'(msg_len), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
